muler_iter: RTL and testbench

//  Parametrised iterative integer multiplier; successor to the fixed 64-bit muler.

---
 rtl/muler_iter.sv | 118 +++++++++++
 tb/tb_muler_iter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muler_iter.sv
// Iterative shift-add integer multiplier for RV64 MUL/MULH/MULHSU/MULHU/MULW.
// Retires STEP multiplier bits per CALC cycle; sign fix-up happens in a dedicated FIX cycle.
module muler_iter #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned STEP = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            mul_valid,
  input  logic            flush,
  input  logic            mulw,
  input  logic [1:0]      mul_signed,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  output logic            mul_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_hi,
  output logic [XLEN-1:0] result_lo
);

  if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8) ||
      (XLEN % STEP) != 0 || (XLEN % 2) != 0 || XLEN < 32) begin : g_bad_param
    $error("muler_iter: unsupported XLEN/STEP combination");
  end

  localparam int unsigned CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state, state_nxt;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] mcand;
  logic [XLEN-1:0]   mplier;
  logic [CW-1:0]     count;
  logic              neg;
  logic              is_w;

  logic [XLEN-1:0]   op_mask, a_w, b_w, a_mag, b_mag;
  logic              sa, sb, accept;
  logic [2*XLEN-1:0] partial, fixed;

  // Operands are conditioned to magnitudes at N-bit width; |most-negative| still fits unsigned N bits.
  always_comb begin
    op_mask = mulw ? {{(XLEN-32){1'b0}}, 32'hFFFF_FFFF} : '1;
    a_w     = multiplicand & op_mask;
    b_w     = multiplier & op_mask;
    sa      = mul_signed[1] & (mulw ? multiplicand[31] : multiplicand[XLEN-1]);
    sb      = (mul_signed == 2'b11) & (mulw ? multiplier[31] : multiplier[XLEN-1]);
    a_mag   = (sa ? -a_w : a_w) & op_mask;
    b_mag   = (sb ? -b_w : b_w) & op_mask;
    accept  = (state == IDLE) & mul_valid & ~flush;
  end

  always_comb begin
    partial = '0;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (mplier[i]) partial = partial + (mcand << i);
    end
    fixed = neg ? -prod : prod;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: if (count == CW'(1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prod      <= '0;
      mcand     <= '0;
      mplier    <= '0;
      count     <= '0;
      neg       <= 1'b0;
      is_w      <= 1'b0;
      result_hi <= '0;
      result_lo <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          mcand  <= {{XLEN{1'b0}}, a_mag};
          mplier <= b_mag;
          prod   <= '0;
          neg    <= sa ^ sb;
          is_w   <= mulw;
          count  <= mulw ? CW'(32 / STEP) : CW'(XLEN / STEP);
        end
        CALC: if (!flush) begin
          prod   <= prod + partial;
          mcand  <= mcand << STEP;
          mplier <= mplier >> STEP;
          count  <= count - CW'(1);
        end
        FIX: if (!flush) begin
          result_hi <= is_w ? '0 : fixed[2*XLEN-1:XLEN];
          result_lo <= is_w ? {{(XLEN-32){fixed[31]}}, fixed[31:0]} : fixed[XLEN-1:0];
        end
        default: ;
      endcase
    end
  end

  assign mul_ready = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_muler_iter.sv
// Directed and randomised checks of muler_iter against a wide-multiply reference model,
// with expected products queued at issue and compared when the result appears.
module tb_muler_iter;

  logic        clock;
  logic        reset;
  logic        mul_valid, sw_valid, flush, mulw, out_ready;
  logic [1:0]  mul_signed;
  logic [63:0] multiplicand, multiplier;
  logic        mul_ready, out_valid;
  logic [63:0] result_hi, result_lo;

  logic [2:0]  s_ready, s_valid;
  logic [63:0] s_hi [3];
  logic [63:0] s_lo [3];

  int checks = 0;
  int errors = 0;
  logic [127:0] sb_q [$];

  muler_iter #(.XLEN(64), .STEP(2)) u_dut (
    .clock(clock), .reset(reset), .mul_valid(mul_valid), .flush(flush), .mulw(mulw),
    .mul_signed(mul_signed), .multiplicand(multiplicand), .multiplier(multiplier),
    .mul_ready(mul_ready), .out_valid(out_valid), .out_ready(out_ready),
    .result_hi(result_hi), .result_lo(result_lo));

  muler_iter #(.XLEN(64), .STEP(1)) u_s1 (
    .clock(clock), .reset(reset), .mul_valid(sw_valid), .flush(flush), .mulw(mulw),
    .mul_signed(mul_signed), .multiplicand(multiplicand), .multiplier(multiplier),
    .mul_ready(s_ready[0]), .out_valid(s_valid[0]), .out_ready(1'b1),
    .result_hi(s_hi[0]), .result_lo(s_lo[0]));

  muler_iter #(.XLEN(64), .STEP(4)) u_s4 (
    .clock(clock), .reset(reset), .mul_valid(sw_valid), .flush(flush), .mulw(mulw),
    .mul_signed(mul_signed), .multiplicand(multiplicand), .multiplier(multiplier),
    .mul_ready(s_ready[1]), .out_valid(s_valid[1]), .out_ready(1'b1),
    .result_hi(s_hi[1]), .result_lo(s_lo[1]));

  muler_iter #(.XLEN(64), .STEP(8)) u_s8 (
    .clock(clock), .reset(reset), .mul_valid(sw_valid), .flush(flush), .mulw(mulw),
    .mul_signed(mul_signed), .multiplicand(multiplicand), .multiplier(multiplier),
    .mul_ready(s_ready[2]), .out_valid(s_valid[2]), .out_ready(1'b1),
    .result_hi(s_hi[2]), .result_lo(s_lo[2]));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                           input logic [1:0] sg, input logic w);
    logic [127:0] ea, eb, p;
    if (w) begin
      ea = sg[1] ? {{96{a[31]}}, a[31:0]} : {96'b0, a[31:0]};
      eb = (sg == 2'b11) ? {{96{b[31]}}, b[31:0]} : {96'b0, b[31:0]};
      p  = ea * eb;
      return {64'b0, {32{p[31]}}, p[31:0]};
    end
    ea = sg[1] ? {{64{a[63]}}, a} : {64'b0, a};
    eb = (sg == 2'b11) ? {{64{b[63]}}, b} : {64'b0, b};
    p  = ea * eb;
    return p;
  endfunction

  function automatic int step_of(input int idx);
    return (idx == 0) ? 1 : (idx == 1) ? 4 : 8;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ops(input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] sg, input logic w);
    multiplicand = a;
    multiplier   = b;
    mul_signed   = sg;
    mulw         = w;
  endtask

  task automatic issue(input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] sg, input logic w, input bit push);
    check("ready_before_issue", 128'(mul_ready), 128'(1'b1));
    set_ops(a, b, sg, w);
    mul_valid = 1'b1;
    if (push) sb_q.push_back(ref_mul(a, b, sg, w));
    tick();
    mul_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int exp_lat);
    int n;
    logic [127:0] e;
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 128'(n), 128'(exp_lat));
    e = sb_q.pop_front();
    check({tag, "_hi"}, 128'(result_hi), 128'(e[127:64]));
    check({tag, "_lo"}, 128'(result_lo), 128'(e[63:0]));
    tick();
  endtask

  task automatic run_sweep(input logic [63:0] a, input logic [63:0] b,
                           input logic [1:0] sg, input logic w);
    bit seen [3];
    int lat [3];
    logic [127:0] got [3];
    logic [127:0] e;
    int n;
    for (int i = 0; i < 3; i++) begin
      seen[i] = 1'b0;
      lat[i]  = -1;
      got[i]  = '0;
    end
    set_ops(a, b, sg, w);
    sw_valid = 1'b1;
    sb_q.push_back(ref_mul(a, b, sg, w));
    tick();
    sw_valid = 1'b0;
    n = 0;
    while (!(seen[0] && seen[1] && seen[2]) && n < 100) begin
      tick();
      n++;
      for (int i = 0; i < 3; i++) begin
        if (s_valid[i] && !seen[i]) begin
          seen[i] = 1'b1;
          lat[i]  = n;
          got[i]  = {s_hi[i], s_lo[i]};
        end
      end
    end
    e = sb_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("sweep_s%0d_latency", step_of(i)), 128'(lat[i]),
            128'((w ? 32 : 64) / step_of(i) + 1));
      check($sformatf("sweep_s%0d_product", step_of(i)), got[i], e);
    end
    tick();
  endtask

  initial begin
    bit leaked;
    logic [127:0] e;
    int n;

    reset = 1'b0; mul_valid = 1'b0; sw_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    set_ops(64'd0, 64'd0, 2'b00, 1'b0);
    #1;
    check("reset_ctrl", 128'({mul_ready, out_valid}), 128'(2'b10));
    check("reset_result", {result_hi, result_lo}, 128'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    tick();

    // Directed products on the STEP=2 instance
    issue(64'd7, -64'sd3, 2'b11, 1'b0, 1'b1);
    wait_result("t1_7x-3", 33);
    issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b11, 1'b0, 1'b1);
    wait_result("t2_minmin_ss", 33);
    issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b10, 1'b0, 1'b1);
    wait_result("t2_minmin_su", 33);
    issue(64'h1_7FFF_FFFF, 64'd2, 2'b00, 1'b1, 1'b1);
    wait_result("t3_mulw", 17);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 1'b0, 1'b1);
    wait_result("signed01_as_unsigned", 33);
    issue(64'hDEAD_BEEF_8000_0000, 64'h1234_5678_8000_0000, 2'b11, 1'b1, 1'b1);
    wait_result("mulw_minmin", 17);

    // Backpressure: result held while out_ready is low
    out_ready = 1'b0;
    issue(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 2'b10, 1'b0, 1'b1);
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    check("bp_latency", 128'(n), 128'(33));
    e = sb_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_ctrl", 128'({out_valid, mul_ready}), 128'(2'b10));
      check("bp_hold_data", {result_hi, result_lo}, e);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_ctrl", 128'({out_valid, mul_ready}), 128'(2'b01));

    // Flush mid-CALC, then flush together with a request in IDLE
    issue(64'd1000, 64'd1000, 2'b00, 1'b0, 1'b0);
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_calc_ctrl", 128'({out_valid, mul_ready}), 128'(2'b01));
    set_ops(64'd9, 64'd9, 2'b00, 1'b0);
    flush = 1'b1;
    mul_valid = 1'b1;
    tick();
    flush = 1'b0;
    mul_valid = 1'b0;
    check("flush_idle_not_accepted", 128'({out_valid, mul_ready}), 128'(2'b01));
    leaked = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid || !mul_ready) leaked = 1'b1;
      tick();
    end
    check("flush_no_output", 128'(leaked), 128'(1'b0));
    issue(64'd3, 64'd5, 2'b11, 1'b0, 1'b1);
    wait_result("after_flush_3x5", 33);

    // STEP sweep against the reference model
    run_sweep(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b11, 1'b0);
    run_sweep(64'h0000_0000_8000_0000, 64'h0000_0000_7FFF_FFFF, 2'b11, 1'b1);
    for (int k = 0; k < 6; k++) begin
      run_sweep({$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)));
    end

    // Async reset mid-CALC: outputs drop without a clock edge
    issue(64'hFFFF_0000_1234_5678, 64'h0000_FFFF_8765_4321, 2'b11, 1'b0, 1'b0);
    set_ops(64'hFFFF_0000_1234_5678, 64'h0000_FFFF_8765_4321, 2'b11, 1'b0);
    sw_valid = 1'b1;
    tick();
    sw_valid = 1'b0;
    repeat (4) tick();
    #2 reset = 1'b0;
    #1;
    check("areset_main_ctrl", 128'({out_valid, mul_ready}), 128'(2'b01));
    check("areset_main_data", {result_hi, result_lo}, 128'd0);
    check("areset_sweep_ctrl", 128'({s_valid, s_ready}), 128'(6'b000_111));
    check("areset_s4_data", {s_hi[1], s_lo[1]}, 128'd0);
    #1 reset = 1'b1;
    leaked = 1'b0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (out_valid || (s_valid != 3'b000)) leaked = 1'b1;
    end
    check("areset_no_partial_output", 128'(leaked), 128'(1'b0));
    issue(-64'sd6, 64'd7, 2'b11, 1'b0, 1'b1);
    wait_result("after_reset_-6x7", 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
